// File: rtl/hr_nlane_ser.sv
// hr_nlane_ser: N-lane parallel-to-serial converter with one-word hold buffer, word clock and underflow tracking.
// Optional SER_PRBS_IDLE_EN: idle words carry PRBS7 bits instead of zeros.
module hr_nlane_ser #(
   parameter int LANES     = 4,
   parameter int RATIO     = 4,
   parameter int LSB_FIRST = 1
) (
   input  logic                   clk_hr,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [LANES*RATIO-1:0] din,
   input  logic                   din_valid,
   output logic                   din_ready,
   input  logic                   underflow_clr,
   output logic [LANES-1:0]       dout,
   output logic                   clk_word,
   output logic                   underflow,
   output logic [15:0]            words_sent
);
   localparam int CW = $clog2(RATIO);
   localparam int W  = LANES*RATIO;
   typedef enum logic {OFF, RUN} state_t;
   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [W-1:0]     r_hold, r_sh, w_sh_nxt, w_word, w_src, w_idle;
   logic [LANES-1:0] r_dout, w_dout_nxt;
   logic [15:0]      r_ws;
   logic             r_full, r_clk_word, r_uf;
   logic             w_run, w_load, w_wr, w_bypass, w_uf_set;
   // Next state follows en; a running cycle is a load cycle when the bit counter wraps.
   always_comb begin
      w_run       = (r_state == RUN) && en;
      w_load      = w_run && (r_cnt == CW'(RATIO-1));
      w_state_nxt = en ? RUN : OFF;
      w_cnt_nxt   = !w_run ? CW'(RATIO-1) : (w_load ? '0 : r_cnt + CW'(1));
   end
   assign din_ready = !r_full || w_load;
   assign w_wr      = din_valid && din_ready;
   assign w_bypass  = w_load && !r_full && w_wr;
   assign w_uf_set  = w_load && !r_full && !w_wr;
   assign w_word    = r_full ? r_hold : (w_wr ? din : w_idle);
   assign w_src     = w_load ? w_word : r_sh;
`ifdef SER_PRBS_IDLE_EN
   logic [6:0]       r_lfsr, w_lfsr_nxt;
   logic [RATIO-1:0] w_pat;
   // Run the PRBS7 RATIO steps ahead, placing bits so the line carries them in generation order.
   always_comb begin
      w_lfsr_nxt = r_lfsr;
      w_pat      = '0;
      for (int i = 0; i < RATIO; i++) begin
         w_pat[LSB_FIRST ? i : RATIO-1-i] = w_lfsr_nxt[6] ^ w_lfsr_nxt[5];
         w_lfsr_nxt = {w_lfsr_nxt[5:0], w_lfsr_nxt[6] ^ w_lfsr_nxt[5]};
      end
   end
   // LFSR advances only when an idle word is actually loaded.
   always_ff @(posedge clk_hr or negedge rst_n) begin
      if (!rst_n)        r_lfsr <= 7'h7F;
      else if (w_uf_set) r_lfsr <= w_lfsr_nxt;
   end
   assign w_idle = {LANES{w_pat}};
`else
   assign w_idle = '0;
`endif
   // Per lane: emit the leading bit of the source word and shift the remainder towards it.
   always_comb begin
      w_dout_nxt = '0;
      w_sh_nxt   = '0;
      for (int k = 0; k < LANES; k++) begin
         w_dout_nxt[k]              = w_src[k*RATIO + (LSB_FIRST ? 0 : RATIO-1)];
         w_sh_nxt[k*RATIO +: RATIO] = LSB_FIRST ? (w_src[k*RATIO +: RATIO] >> 1) : (w_src[k*RATIO +: RATIO] << 1);
      end
   end
   // State register and bit counter.
   always_ff @(posedge clk_hr or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= OFF;
         r_cnt   <= CW'(RATIO-1);
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end
   // Hold buffer, shifters, registered outputs and status; leaving RUN clears the line but keeps hold.
   always_ff @(posedge clk_hr or negedge rst_n) begin
      if (!rst_n) begin
         r_hold     <= '0;
         r_full     <= 1'b0;
         r_sh       <= '0;
         r_dout     <= '0;
         r_clk_word <= 1'b0;
         r_uf       <= 1'b0;
         r_ws       <= '0;
      end else begin
         if (w_wr && !w_bypass) r_hold <= din;
         r_full     <= w_load ? (r_full && w_wr) : (r_full || w_wr);
         r_sh       <= w_run ? w_sh_nxt : '0;
         r_dout     <= w_run ? w_dout_nxt : '0;
         r_clk_word <= !w_cnt_nxt[CW-1];
         r_uf       <= w_uf_set || (r_uf && !underflow_clr);
         if (w_load && !w_uf_set) r_ws <= r_ws + 16'd1;
      end
   end
   assign dout       = r_dout;
   assign clk_word   = r_clk_word;
   assign underflow  = r_uf;
   assign words_sent = r_ws;
endmodule

// File: doc/hr_nlane_ser.md
HR_NLANE_SER -- requirements
Module: hr_nlane_ser

Interface
REQ-001 SHALL have parameter LANES, default 4: number of serial output lanes (1..16).
REQ-002 SHALL have parameter RATIO, default 4: bits per lane per word (power of two, 2..16).
REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 = lane bit 0 is serialised first, 0 = bit RATIO-1 first.
REQ-004 SHALL have port clk_hr, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1: serialiser run enable.
REQ-007 SHALL have port din, input, LANES*RATIO: parallel word; lane k uses din[k*RATIO +: RATIO].
REQ-008 SHALL have port din_valid, input, 1: din holds a valid word.
REQ-009 SHALL have port din_ready, output, 1: block accepts din this cycle.
REQ-010 SHALL have port underflow_clr, input, 1: clears the sticky underflow flag.
REQ-011 SHALL have port dout, output, LANES: serial lane data, registered.
REQ-012 SHALL have port clk_word, output, 1: word-rate clock (period RATIO cycles), registered.
REQ-013 SHALL have port underflow, output, 1: sticky flag, set when an idle word was sent.
REQ-014 SHALL have port words_sent, output, 16: count of data words loaded, wraps 16'hFFFF -> 0.

Function
REQ-015 SHALL hold a one-word buffer (hold) and a per-lane RATIO-bit shift register.
REQ-016 SHALL implement FSM with states OFF and RUN: OFF -> RUN when en=1; RUN -> OFF when en=0.
REQ-017 SHALL keep bit counter cnt = RATIO-1 in OFF, so the first RUN cycle is a load cycle.
REQ-018 SHALL, in RUN, treat cnt = RATIO-1 as a load cycle (cnt -> 0); otherwise increment cnt.
REQ-019 SHALL drive din_ready = !hold_full || (load cycle && hold_full), in both states.
REQ-020 SHALL capture din into hold on din_valid && din_ready.
REQ-021 SHALL, on a load cycle, take hold into the shifters and emit its first bits on dout at that edge. When hold is empty, a write in the same cycle goes straight to the shifters; otherwise that write refills hold.
REQ-022 SHALL, on a load cycle with hold empty and no write, load the idle word, set underflow, and leave words_sent unchanged.
REQ-023 SHALL increment words_sent by 1 per data-word load.
REQ-024 SHALL shift one bit per lane per RUN cycle, in the order set by LSB_FIRST.
REQ-025 SHALL give latency: a word written into an empty block with cnt = RATIO-1 appears on dout at the same edge; its last bit leaves RATIO-1 edges later.
REQ-026 SHALL drive clk_word = 1 when cnt is in 0..RATIO/2-1, 0 otherwise; constant 0 in OFF.
REQ-027 SHALL let set win when underflow_clr and an underflow set occur in the same cycle.
REQ-028 SHALL, when en falls mid-word, abort the word: dout = 0 at the next edge, shifters cleared, hold kept, cnt = RATIO-1.
REQ-029 SHALL keep dout = 0 in OFF; hold may still be filled in OFF.

Reset
REQ-030 SHALL, while rst_n = 0, force asynchronously: state = OFF, cnt = RATIO-1, hold empty, shifters 0, dout = 0, clk_word = 0, underflow = 0, words_sent = 0, din_ready = 1.
REQ-031 SHALL discard any word in flight or in hold when reset is asserted mid-operation.

Configuration
REQ-032 SHALL, with SER_PRBS_IDLE_EN defined, make the idle word RATIO consecutive bits of a PRBS7 (x^7+x^6+1, seed 7'h7F) replicated on every lane. The LFSR advances RATIO steps per idle load and resets to seed.
REQ-033 SHALL, without SER_PRBS_IDLE_EN, make the idle word all zeros and include no LFSR.

Verification (LANES=4, RATIO=4, LSB_FIRST=1)
REQ-034 SHALL check reset: rst_n=0 mid-stream -> dout=4'h0, clk_word=0, din_ready=1, underflow=0, words_sent=0, immediately.
REQ-035 SHALL check ordering: en=1, din=16'hA5C3 valid on the first cycle -> dout[0]=1,1,0,0; dout[1]=0,0,1,1; dout[2]=1,0,1,0; dout[3]=0,1,0,1 on 4 consecutive edges; words_sent=1.
REQ-036 SHALL check streaming: din_valid held with words 0,1,2,... for 64 cycles -> no underflow, words_sent=16, clk_word period 4 cycles, duty 2/2.
REQ-037 SHALL check underflow: en=1 with din_valid=0 -> dout=4'h0 (macro off), underflow=1. Then underflow_clr for 1 cycle -> 0; clr coincident with the next load -> stays 1.
REQ-038 SHALL check abort: en dropped at cnt=1 of a word -> dout=0 next edge, clk_word=0. Re-enable -> the held word loads on the first cycle.
REQ-039 SHALL check PRBS idle: SER_PRBS_IDLE_EN defined, no data -> all four lanes identical and matching the PRBS7 model bit-for-bit over 127 idle bits.
